// File: rtl/if_stage.sv
// if_stage: instruction fetch with PC, IF/ID register, stall, redirect/flush and halt-on-marker.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hDEAD_BEEF,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_raddr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic        halted,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);
  typedef enum logic {RUN, HALT} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, id_pc_q, id_pc_d, id_instr_q, id_instr_d;
  logic [31:0] id_pc_plus4_q, id_pc_plus4_d, fetch_count_q, fetch_count_d;
  logic        id_valid_q, id_valid_d, halted_q, halted_d, misalign_q, misalign_d;
  logic [31:0] pc_plus4;
  assign pc_plus4 = pc_q + 32'd4;
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    id_valid_d    = id_valid_q;
    id_pc_d       = id_pc_q;
    id_instr_d    = id_instr_q;
    id_pc_plus4_d = id_pc_plus4_q;
    halted_d      = halted_q;
    misalign_d    = misalign_q;
    fetch_count_d = fetch_count_q;
    if (state_q == HALT) begin
      id_valid_d = 1'b0;
    end else if (redirect_valid) begin
      // redirect wins over stall and discards whatever is being fetched, including the marker
      pc_d       = {redirect_pc[31:2], 2'b00};
      id_valid_d = 1'b0;
      id_instr_d = NOP_WORD;
      misalign_d = misalign_q | (|redirect_pc[1:0]);
    end else if (!stall) begin
      if (imem_rdata == HALT_WORD) begin
        state_d    = HALT;
        halted_d   = 1'b1;
        id_valid_d = 1'b0;
        id_instr_d = NOP_WORD;
      end else begin
        pc_d          = pc_plus4;
        id_valid_d    = 1'b1;
        id_pc_d       = pc_q;
        id_instr_d    = imem_rdata;
        id_pc_plus4_d = pc_plus4;
        fetch_count_d = fetch_count_q + 32'd1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      id_valid_q    <= 1'b0;
      id_pc_q       <= '0;
      id_instr_q    <= NOP_WORD;
      id_pc_plus4_q <= '0;
      halted_q      <= 1'b0;
      misalign_q    <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      id_valid_q    <= id_valid_d;
      id_pc_q       <= id_pc_d;
      id_instr_q    <= id_instr_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      halted_q      <= halted_d;
      misalign_q    <= misalign_d;
      fetch_count_q <= fetch_count_d;
    end
  end
  assign imem_raddr   = pc_q;
  assign id_valid     = id_valid_q;
  assign id_pc        = id_pc_q;
  assign id_instr     = id_instr_q;
  assign id_pc_plus4  = id_pc_plus4_q;
  assign halted       = halted_q;
  assign misalign_err = misalign_q;
  assign fetch_count  = fetch_count_q;
endmodule
